// File: rtl/id_stage.sv
// id_stage: MIPS R2000 instruction-decode stage.
// Holds the 32x32 register file with a write-back read bypass, the main and ALU
// control decode, immediate extension, branch/jump resolution, load-use and
// branch-operand stall detection, and the ID/EX pipeline register.
// Optional feature: define ID_LINK_EN to decode JAL (link into r31).
module id_stage #(
  parameter int RESET_PC_UNUSED = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] inst_in,
  input  logic [4:0]  write_register,
  input  logic [31:0] write_data_reg,
  input  logic        reg_write,
  input  logic        flush_id,
  output logic        exception,
  output logic        jump,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [31:0] data_1,
  output logic [31:0] data_2,
  output logic [1:0]  wb,
  output logic [2:0]  m,
  output logic [5:0]  ex,
  output logic [31:0] pc_branch,
  output logic        br,
  output logic        hold_pc,
  output logic        hold_if,
  output logic        flush_ex
);

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_ADDU = 4'd1, ALU_SUB = 4'd2, ALU_SUBU = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8, ALU_SLL = 4'd9, ALU_SRL = 4'd10, ALU_LUI = 4'd11;

  logic unused_param;
  assign unused_param = (RESET_PC_UNUSED != 0);

  logic [5:0]  op, funct;
  logic [4:0]  rs_f, rt_f, rd_f;
  logic [31:0] rf_q [32];
  logic [31:0] src_a, src_b, imm_ext, pc_plus4, br_target, j_target;

  logic        valid, reg_dst, alu_src, zext, rs_used, rt_used;
  logic        is_beq, is_bne, is_j, is_jal, is_jr;
  logic [3:0]  alu_op;
  logic [1:0]  wb_c;
  logic [2:0]  m_c;
  logic        load_use, branch_stall, stall, bubble;

  // ID/EX register and shadow destination history
  logic        exception_q, flush_ex_q;
  logic [4:0]  rs_q, rt_q, rd_q, sh1_dst_q, sh2_dst_q;
  logic        sh1_we_q, sh2_we_q;
  logic [31:0] imm_q, data_1_q, data_2_q;
  logic [1:0]  wb_q;
  logic [2:0]  m_q;
  logic [5:0]  ex_q;
  logic [4:0]  rd_d;
  logic [31:0] data_1_d, data_2_d;

  assign op    = inst_in[31:26];
  assign rs_f  = inst_in[25:21];
  assign rt_f  = inst_in[20:16];
  assign rd_f  = inst_in[15:11];
  assign funct = inst_in[5:0];

  // Register file: cleared on reset, written by WB, r0 never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (reg_write && write_register != 5'd0) begin
      rf_q[write_register] <= write_data_reg;
    end
  end

  // Operand reads with same-cycle write-back bypass; r0 always reads zero
  always_comb begin
    src_a = '0;
    src_b = '0;
    if (rs_f != 5'd0) src_a = (reg_write && write_register == rs_f) ? write_data_reg : rf_q[rs_f];
    if (rt_f != 5'd0) src_b = (reg_write && write_register == rt_f) ? write_data_reg : rf_q[rt_f];
  end

  // Main and ALU control decode
  always_comb begin
    valid = 1'b0; reg_dst = 1'b0; alu_src = 1'b0; alu_op = ALU_ADD;
    wb_c = 2'b00; m_c = 3'b000; zext = 1'b0; rs_used = 1'b1; rt_used = 1'b0;
    is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0;
    case (op)
      6'h00: begin
        valid = 1'b1; reg_dst = 1'b1; wb_c = 2'b10; rt_used = 1'b1;
        case (funct)
          6'h20: alu_op = ALU_ADD;
          6'h21: alu_op = ALU_ADDU;
          6'h22: alu_op = ALU_SUB;
          6'h23: alu_op = ALU_SUBU;
          6'h24: alu_op = ALU_AND;
          6'h25: alu_op = ALU_OR;
          6'h26: alu_op = ALU_XOR;
          6'h27: alu_op = ALU_NOR;
          6'h2A: alu_op = ALU_SLT;
          6'h00: alu_op = ALU_SLL;
          6'h02: alu_op = ALU_SRL;
          6'h08: begin
            is_jr = 1'b1; reg_dst = 1'b0; wb_c = 2'b00; m_c = 3'b100; rt_used = 1'b0;
          end
          default: valid = 1'b0;
        endcase
      end
      6'h08: begin valid = 1'b1; alu_src = 1'b1; wb_c = 2'b10; alu_op = ALU_ADD;  end
      6'h09: begin valid = 1'b1; alu_src = 1'b1; wb_c = 2'b10; alu_op = ALU_ADDU; end
      6'h0C: begin valid = 1'b1; alu_src = 1'b1; wb_c = 2'b10; alu_op = ALU_AND; zext = 1'b1; end
      6'h0D: begin valid = 1'b1; alu_src = 1'b1; wb_c = 2'b10; alu_op = ALU_OR;  zext = 1'b1; end
      6'h0E: begin valid = 1'b1; alu_src = 1'b1; wb_c = 2'b10; alu_op = ALU_XOR; zext = 1'b1; end
      6'h0A: begin valid = 1'b1; alu_src = 1'b1; wb_c = 2'b10; alu_op = ALU_SLT;  end
      6'h0F: begin valid = 1'b1; alu_src = 1'b1; wb_c = 2'b10; alu_op = ALU_LUI;  end
      6'h23: begin valid = 1'b1; alu_src = 1'b1; wb_c = 2'b11; m_c = 3'b010; alu_op = ALU_ADDU; end
      6'h2B: begin
        valid = 1'b1; alu_src = 1'b1; m_c = 3'b001; alu_op = ALU_ADDU; rt_used = 1'b1;
      end
      6'h04: begin valid = 1'b1; m_c = 3'b100; alu_op = ALU_SUBU; is_beq = 1'b1; rt_used = 1'b1; end
      6'h05: begin valid = 1'b1; m_c = 3'b100; alu_op = ALU_SUBU; is_bne = 1'b1; rt_used = 1'b1; end
      6'h02: begin valid = 1'b1; m_c = 3'b100; is_j = 1'b1; rs_used = 1'b0; end
`ifdef ID_LINK_EN
      6'h03: begin
        valid = 1'b1; reg_dst = 1'b1; wb_c = 2'b10; alu_op = ALU_ADDU; is_jal = 1'b1; rs_used = 1'b0;
      end
`endif
      default: valid = 1'b0;
    endcase
  end

  // Immediate extension and redirect targets
  assign imm_ext   = zext ? {16'h0000, inst_in[15:0]} : {{16{inst_in[15]}}, inst_in[15:0]};
  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], inst_in[25:0], 2'b00};

  // Hazard detection: load-use against ID/EX, branch/jr sources against both shadow dests
  always_comb begin
    load_use = m_q[1] && (rt_q != 5'd0) &&
               ((rs_used && rs_f == rt_q) || (rt_used && rt_f == rt_q));
    branch_stall = 1'b0;
    if (is_beq || is_bne || is_jr) begin
      if (rs_f != 5'd0 && ((sh1_we_q && sh1_dst_q == rs_f) || (sh2_we_q && sh2_dst_q == rs_f)))
        branch_stall = 1'b1;
      if (!is_jr && rt_f != 5'd0 &&
          ((sh1_we_q && sh1_dst_q == rt_f) || (sh2_we_q && sh2_dst_q == rt_f)))
        branch_stall = 1'b1;
    end
    stall  = valid && (load_use || branch_stall);
    bubble = flush_id || stall || !valid;
  end

  // Redirect outputs
  assign jump      = is_j || is_jal || is_jr;
  assign hold_pc   = stall;
  assign hold_if   = stall;
  assign pc_branch = is_jr ? src_a : ((is_j || is_jal) ? j_target : br_target);
  assign br        = valid && !stall &&
                     (is_j || is_jal || is_jr || (is_beq && src_a == src_b) || (is_bne && src_a != src_b));

  assign rd_d     = is_jal ? 5'd31 : rd_f;
  assign data_1_d = is_jal ? (pc + 32'd8) : src_a;
  assign data_2_d = is_jal ? 32'd0 : src_b;

  // ID/EX register; bubbles zero the controls, shadow history shifts every cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exception_q <= 1'b0; flush_ex_q <= 1'b0;
      rs_q <= '0; rt_q <= '0; rd_q <= '0; imm_q <= '0; data_1_q <= '0; data_2_q <= '0;
      wb_q <= '0; m_q <= '0; ex_q <= '0;
      sh1_dst_q <= '0; sh1_we_q <= 1'b0; sh2_dst_q <= '0; sh2_we_q <= 1'b0;
    end else begin
      exception_q <= !flush_id && !valid;
      flush_ex_q  <= bubble;
      rs_q <= rs_f; rt_q <= rt_f; rd_q <= rd_d; imm_q <= imm_ext;
      data_1_q <= data_1_d; data_2_q <= data_2_d;
      wb_q <= bubble ? 2'b00 : wb_c;
      m_q  <= bubble ? 3'b000 : m_c;
      ex_q <= bubble ? 6'b000000 : {reg_dst, alu_src, alu_op};
      sh2_dst_q <= sh1_dst_q; sh2_we_q <= sh1_we_q;
      sh1_dst_q <= reg_dst ? rd_d : rt_f;
      sh1_we_q  <= !bubble && wb_c[1];
    end
  end

  assign exception = exception_q;
  assign flush_ex  = flush_ex_q;
  assign rs = rs_q;  assign rt = rt_q;  assign rd = rd_q;
  assign imm = imm_q;  assign data_1 = data_1_q;  assign data_2 = data_2_q;
  assign wb = wb_q;  assign m = m_q;  assign ex = ex_q;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed-vector bench for id_stage. Inputs change 1ns after the
// rising edge; combinational outputs are sampled 1ns later, registered outputs
// 1ns after the following rising edge.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, inst_in, write_data_reg;
  logic [4:0]  write_register;
  logic        reg_write, flush_id;
  logic        exception, jump, br, hold_pc, hold_if, flush_ex;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm, data_1, data_2, pc_branch;
  logic [1:0]  wb;
  logic [2:0]  m;
  logic [5:0]  ex;
  int vectors = 0;
  int miscompares = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .pc(pc), .inst_in(inst_in), .write_register(write_register),
    .write_data_reg(write_data_reg), .reg_write(reg_write), .flush_id(flush_id),
    .exception(exception), .jump(jump), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .data_1(data_1), .data_2(data_2), .wb(wb), .m(m), .ex(ex), .pc_branch(pc_branch),
    .br(br), .hold_pc(hold_pc), .hold_if(hold_if), .flush_ex(flush_ex)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] f);
    return {6'h00, s, t, d, 5'd0, f};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] i);
    return {o, s, t, i};
  endfunction
  function automatic logic [31:0] jtype(input logic [5:0] o, input logic [25:0] t);
    return {o, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    write_register = r; write_data_reg = d; reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc = '0; inst_in = '0; write_register = '0; write_data_reg = '0;
    reg_write = 1'b0; flush_id = 1'b0;
    #2;
    vectors++;
    if ({exception, rs, rt, rd, imm, data_1, data_2, wb, m, ex, flush_ex} !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: got exc=%b wb=%b m=%b ex=%b d1=%h want all zero", exception, wb, m, ex, data_1);
    end
    vectors++;
    if ({hold_pc, br, jump} !== 3'b000) begin
      miscompares++; $display("FAIL reset_comb: got hold/br/jump=%b want 000", {hold_pc, br, jump});
    end
    @(negedge clk); rst = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    write_register = 5'd8; write_data_reg = 32'h1234; reg_write = 1'b1;
    inst_in = rtype(5'd8, 5'd8, 5'd9, 6'h20); pc = 32'h0;
    tick();
    reg_write = 1'b0; inst_in = rtype(5'd8, 5'd0, 5'd10, 6'h20);
    vectors++;
    if (data_1 !== 32'h1234 || data_2 !== 32'h1234) begin
      miscompares++; $display("FAIL bypass_data: got %h/%h want 00001234/00001234", data_1, data_2);
    end
    vectors++;
    if (ex !== 6'b100000 || wb !== 2'b10 || rd !== 5'd9 || flush_ex !== 1'b0) begin
      miscompares++; $display("FAIL bypass_ctrl: got ex=%b wb=%b rd=%0d fx=%b want 100000 10 9 0", ex, wb, rd, flush_ex);
    end
    tick();
    inst_in = '0;
    vectors++;
    if (data_1 !== 32'h1234 || data_2 !== 32'h0) begin
      miscompares++; $display("FAIL rf_read: got %h/%h want 00001234/00000000", data_1, data_2);
    end
  endtask

  task automatic test_load_use();
    inst_in = itype(6'h23, 5'd2, 5'd5, 16'd4);
    tick();
    vectors++;
    if (m !== 3'b010 || wb !== 2'b11 || ex !== 6'b010001 || imm !== 32'd4) begin
      miscompares++; $display("FAIL lw_ctrl: got m=%b wb=%b ex=%b imm=%h want 010 11 010001 4", m, wb, ex, imm);
    end
    inst_in = rtype(5'd5, 5'd1, 5'd6, 6'h20);
    #1;
    vectors++;
    if ({hold_pc, hold_if, br} !== 3'b110) begin
      miscompares++; $display("FAIL load_use_hold: got %b want 110", {hold_pc, hold_if, br});
    end
    tick();
    vectors++;
    if (flush_ex !== 1'b1 || wb !== 2'b00 || m !== 3'b000 || ex !== 6'b0) begin
      miscompares++; $display("FAIL load_use_bubble: got fx=%b wb=%b m=%b ex=%b want 1 00 000 0", flush_ex, wb, m, ex);
    end
    vectors++;
    if (hold_pc !== 1'b0) begin
      miscompares++; $display("FAIL load_use_release: got hold_pc=%b want 0", hold_pc);
    end
    tick();
    inst_in = '0;
    vectors++;
    if (flush_ex !== 1'b0 || wb !== 2'b10 || rd !== 5'd6) begin
      miscompares++; $display("FAIL load_use_issue: got fx=%b wb=%b rd=%0d want 0 10 6", flush_ex, wb, rd);
    end
  endtask

  task automatic test_branch();
    wb_write(5'd1, 32'h55);
    wb_write(5'd2, 32'h55);
    tick(); tick();
    pc = 32'h40; inst_in = itype(6'h04, 5'd1, 5'd2, 16'd3);
    #1;
    vectors++;
    if (br !== 1'b1 || pc_branch !== 32'h50 || hold_pc !== 1'b0) begin
      miscompares++; $display("FAIL beq_taken: got br=%b tgt=%h hold=%b want 1 00000050 0", br, pc_branch, hold_pc);
    end
    write_register = 5'd2; write_data_reg = 32'h66; reg_write = 1'b1;
    #1;
    vectors++;
    if (br !== 1'b0) begin
      miscompares++; $display("FAIL beq_not_taken: got br=%b want 0", br);
    end
    tick();
    reg_write = 1'b0;
    vectors++;
    if (m !== 3'b100 || wb !== 2'b00) begin
      miscompares++; $display("FAIL beq_ctrl: got m=%b wb=%b want 100 00", m, wb);
    end
    inst_in = itype(6'h05, 5'd1, 5'd2, 16'hFFFF);
    #1;
    vectors++;
    if (br !== 1'b1 || pc_branch !== 32'h40) begin
      miscompares++; $display("FAIL bne_back: got br=%b tgt=%h want 1 00000040", br, pc_branch);
    end
    tick();
    inst_in = itype(6'h08, 5'd0, 5'd3, 16'd7);
    tick();
    inst_in = itype(6'h04, 5'd3, 5'd0, 16'd1);
    #1;
    vectors++;
    if (hold_pc !== 1'b1 || br !== 1'b0) begin
      miscompares++; $display("FAIL br_stall_idex: got hold=%b br=%b want 1 0", hold_pc, br);
    end
    tick();
    vectors++;
    if (hold_if !== 1'b1 || flush_ex !== 1'b1) begin
      miscompares++; $display("FAIL br_stall_exmem: got hold_if=%b fx=%b want 1 1", hold_if, flush_ex);
    end
    tick();
    vectors++;
    if (hold_pc !== 1'b0 || br !== 1'b1 || pc_branch !== 32'h48) begin
      miscompares++; $display("FAIL br_stall_release: got hold=%b br=%b tgt=%h want 0 1 00000048", hold_pc, br, pc_branch);
    end
    tick();
    inst_in = '0;
  endtask

  task automatic test_exception();
    inst_in = {6'h3F, 26'h0};
    #1;
    vectors++;
    if (br !== 1'b0) begin
      miscompares++; $display("FAIL undef_br: got br=%b want 0", br);
    end
    tick();
    inst_in = itype(6'h08, 5'd0, 5'd4, 16'd5); flush_id = 1'b1;
    vectors++;
    if (exception !== 1'b1 || wb !== 2'b00 || m !== 3'b000 || ex !== 6'b0 || flush_ex !== 1'b1) begin
      miscompares++; $display("FAIL undef_op: got exc=%b wb=%b m=%b ex=%b fx=%b want 1 00 000 0 1", exception, wb, m, ex, flush_ex);
    end
    tick();
    flush_id = 1'b0;
    vectors++;
    if (exception !== 1'b0 || flush_ex !== 1'b1 || wb !== 2'b00) begin
      miscompares++; $display("FAIL flush_id: got exc=%b fx=%b wb=%b want 0 1 00", exception, flush_ex, wb);
    end
    tick();
    inst_in = rtype(5'd1, 5'd2, 5'd3, 6'h3F);
    vectors++;
    if (exception !== 1'b0 || flush_ex !== 1'b0 || wb !== 2'b10 || ex !== 6'b010000 || imm !== 32'd5) begin
      miscompares++; $display("FAIL addi: got exc=%b fx=%b wb=%b ex=%b imm=%h want 0 0 10 010000 5", exception, flush_ex, wb, ex, imm);
    end
    tick();
    inst_in = itype(6'h0C, 5'd0, 5'd4, 16'h8000);
    vectors++;
    if (exception !== 1'b1 || flush_ex !== 1'b1) begin
      miscompares++; $display("FAIL undef_funct: got exc=%b fx=%b want 1 1", exception, flush_ex);
    end
    tick();
    inst_in = itype(6'h08, 5'd0, 5'd4, 16'h8000);
    vectors++;
    if (imm !== 32'h0000_8000 || ex !== 6'b010100) begin
      miscompares++; $display("FAIL andi_zext: got imm=%h ex=%b want 00008000 010100", imm, ex);
    end
    tick();
    inst_in = '0;
    vectors++;
    if (imm !== 32'hFFFF_8000) begin
      miscompares++; $display("FAIL addi_sext: got imm=%h want ffff8000", imm);
    end
  endtask

  task automatic test_jump();
    pc = 32'h8000_0010; inst_in = jtype(6'h02, 26'h100);
    #1;
    vectors++;
    if (jump !== 1'b1 || br !== 1'b1 || pc_branch !== 32'h8000_0400) begin
      miscompares++; $display("FAIL j: got jump=%b br=%b tgt=%h want 1 1 80000400", jump, br, pc_branch);
    end
    tick();
    vectors++;
    if (m !== 3'b100 || wb !== 2'b00) begin
      miscompares++; $display("FAIL j_ctrl: got m=%b wb=%b want 100 00", m, wb);
    end
    write_register = 5'd7; write_data_reg = 32'h1000; reg_write = 1'b1;
    inst_in = rtype(5'd7, 5'd0, 5'd0, 6'h08);
    #1;
    vectors++;
    if (jump !== 1'b1 || br !== 1'b1 || pc_branch !== 32'h1000) begin
      miscompares++; $display("FAIL jr: got jump=%b br=%b tgt=%h want 1 1 00001000", jump, br, pc_branch);
    end
    tick();
    reg_write = 1'b0; inst_in = '0;
  endtask

  task automatic test_link();
    pc = 32'h10; inst_in = jtype(6'h03, 26'h100);
    #1;
`ifdef ID_LINK_EN
    vectors++;
    if (br !== 1'b1 || jump !== 1'b1 || pc_branch !== 32'h400) begin
      miscompares++; $display("FAIL jal_redirect: got br=%b jump=%b tgt=%h want 1 1 00000400", br, jump, pc_branch);
    end
    tick();
    inst_in = '0;
    vectors++;
    if (rd !== 5'd31 || data_1 !== 32'h18 || data_2 !== 32'h0 || wb !== 2'b10 || ex !== 6'b100001) begin
      miscompares++; $display("FAIL jal_link: got rd=%0d d1=%h d2=%h wb=%b ex=%b want 31 18 0 10 100001", rd, data_1, data_2, wb, ex);
    end
`else
    vectors++;
    if (br !== 1'b0) begin
      miscompares++; $display("FAIL jal_undef_br: got br=%b want 0", br);
    end
    tick();
    inst_in = '0;
    vectors++;
    if (exception !== 1'b1 || flush_ex !== 1'b1 || wb !== 2'b00) begin
      miscompares++; $display("FAIL jal_undef: got exc=%b fx=%b wb=%b want 1 1 00", exception, flush_ex, wb);
    end
`endif
    tick();
  endtask

  task automatic test_reset_midrun();
    for (int i = 1; i < 32; i++) wb_write(i[4:0], 32'hA000_0000 | i);
    inst_in = rtype(5'd5, 5'd0, 5'd0, 6'h08);
    #1;
    vectors++;
    if (pc_branch !== 32'hA000_0005) begin
      miscompares++; $display("FAIL pre_reset_r5: got %h want a0000005", pc_branch);
    end
    inst_in = rtype(5'd8, 5'd8, 5'd9, 6'h20);
    tick();
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({exception, rs, rt, rd, imm, data_1, data_2, wb, m, ex, flush_ex} !== '0) begin
      miscompares++; $display("FAIL midrun_reset: got wb=%b ex=%b d1=%h rs=%0d want all zero", wb, ex, data_1, rs);
    end
    for (int i = 1; i < 32; i++) begin
      inst_in = rtype(i[4:0], 5'd0, 5'd0, 6'h08);
      #1;
      vectors++;
      if (pc_branch !== 32'h0) begin
        miscompares++; $display("FAIL midrun_reg r%0d: got %h want 00000000", i, pc_branch);
      end
    end
    inst_in = '0;
    @(negedge clk); rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_branch();
    test_exception();
    test_jump();
    test_link();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
